// File: rtl/fft_power_unloader.sv
// Drains N FFT result bins after fft_done_i, streams re^2+im^2 per bin with a last flag,
// and reports the frame peak (max power, lowest index on ties) one cycle after the last bin.
module fft_power_unloader #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      fft_done_i,
    input  logic                      bin_valid_i,
    input  logic [DATA_WIDTH-1:0]     bin_re_i,
    input  logic [DATA_WIDTH-1:0]     bin_im_i,
    output logic                      bin_ready_o,
    output logic                      dl_busy_o,
    output logic                      pw_valid_o,
    input  logic                      pw_ready_i,
    output logic [2*DATA_WIDTH-1:0]   pw_data_o,
    output logic [$clog2(N)-1:0]      pw_idx_o,
    output logic                      pw_last_o,
    output logic                      peak_valid_o,
    output logic [2*DATA_WIDTH-1:0]   peak_pw_o,
    output logic [$clog2(N)-1:0]      peak_idx_o,
    output logic                      overrun_o
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = IDX_W + 1;
    localparam int PW_W  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEAK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s1_valid_q, s1_valid_d;
    logic [PW_W-1:0]    s1_rr_q, s1_rr_d;
    logic [PW_W-1:0]    s1_ii_q, s1_ii_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic               s1_last_q, s1_last_d;
    logic               s2_valid_q, s2_valid_d;
    logic [PW_W-1:0]    s2_pw_q, s2_pw_d;
    logic [IDX_W-1:0]   s2_idx_q, s2_idx_d;
    logic               s2_last_q, s2_last_d;
    logic [PW_W-1:0]    peak_pw_q, peak_pw_d;
    logic [IDX_W-1:0]   peak_idx_q, peak_idx_d;

    logic               adv;
    logic               accept;
    logic               frame_start;
    logic [PW_W-1:0]    re_ext, im_ext, s1_sum;

    // Handshake: a transfer happens on any cycle where valid and ready are both high;
    // a stalled output (valid & !ready) freezes the whole pipeline and blocks input.
    assign adv         = !(s2_valid_q && !pw_ready_i);
    assign bin_ready_o = (state_q == ST_RUN) && (cnt_q < CNT_W'(N)) && adv;
    assign accept      = bin_valid_i && bin_ready_o;
    assign frame_start = (state_q == ST_IDLE) && fft_done_i;

    // Sign extension makes the low 2*DW bits of the product the exact signed square.
    assign re_ext = {{DATA_WIDTH{bin_re_i[DATA_WIDTH-1]}}, bin_re_i};
    assign im_ext = {{DATA_WIDTH{bin_im_i[DATA_WIDTH-1]}}, bin_im_i};
    assign s1_sum = s1_rr_q + s1_ii_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fft_done_i) state_d = ST_RUN;
            ST_RUN:  if (s2_valid_q && s2_last_q && pw_ready_i) state_d = ST_PEAK;
            ST_PEAK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dl_busy_o    = (state_q != ST_IDLE);
        peak_valid_o = (state_q == ST_PEAK);
        overrun_o    = fft_done_i && (state_q != ST_IDLE);
        pw_valid_o   = s2_valid_q;
        pw_data_o    = s2_pw_q;
        pw_idx_o     = s2_idx_q;
        pw_last_o    = s2_last_q;
        peak_pw_o    = peak_pw_q;
        peak_idx_o   = peak_idx_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_rr_d    = s1_rr_q;
        s1_ii_d    = s1_ii_q;
        s1_idx_d   = s1_idx_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_pw_d    = s2_pw_q;
        s2_idx_d   = s2_idx_q;
        s2_last_d  = s2_last_q;
        peak_pw_d  = peak_pw_q;
        peak_idx_d = peak_idx_q;

        if (frame_start) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_rr_d   = re_ext * re_ext;
                s1_ii_d   = im_ext * im_ext;
                s1_idx_d  = cnt_q[IDX_W-1:0];
                s1_last_d = (cnt_q == CNT_W'(N - 1));
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pw_d   = s1_sum;
                s2_idx_d  = s1_idx_q;
                s2_last_d = s1_last_q;
            end
        end

        // Strict compare keeps the earliest index when powers tie.
        if (frame_start) begin
            peak_pw_d  = '0;
            peak_idx_d = '0;
        end else if (adv && s1_valid_q && (s1_sum > peak_pw_q)) begin
            peak_pw_d  = s1_sum;
            peak_idx_d = s1_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_rr_q    <= '0;
            s1_ii_q    <= '0;
            s1_idx_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pw_q    <= '0;
            s2_idx_q   <= '0;
            s2_last_q  <= 1'b0;
            peak_pw_q  <= '0;
            peak_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_rr_q    <= s1_rr_d;
            s1_ii_q    <= s1_ii_d;
            s1_idx_q   <= s1_idx_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_pw_q    <= s2_pw_d;
            s2_idx_q   <= s2_idx_d;
            s2_last_q  <= s2_last_d;
            peak_pw_q  <= peak_pw_d;
            peak_idx_q <= peak_idx_d;
        end
    end
endmodule
